// File: rtl/startracker_pkg.sv
// Shared constants and state type for the star-tracker histogram path.
package startracker_pkg;

    localparam int CHUNK_BINS = 8;
    localparam int NUM_BINS   = 256;
    localparam int BIN_OUT_W  = 16;
    localparam int NUM_CHUNKS = NUM_BINS / CHUNK_BINS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } hc_state_t;

endpackage

// File: rtl/chunk_prefix_sum.sv
// Combinational tail-sum for one 8-bin chunk: running counts from the top bin down,
// each reduced by the target and clamped to a signed 16-bit bin value.
module chunk_prefix_sum
    import startracker_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int ACC_W   = 24
) (
    input  logic [CHUNK_BINS*COUNT_W-1:0]   i_bins,
    input  logic [ACC_W-1:0]                i_acc,
    input  logic [ACC_W-1:0]                i_target,
    output logic [CHUNK_BINS*BIN_OUT_W-1:0] o_chunk,
    output logic [ACC_W-1:0]                o_next_acc
);

    localparam logic signed [ACC_W:0] POS_MAX = (ACC_W+1)'(2**(BIN_OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] NEG_MIN = (ACC_W+1)'(-(2**(BIN_OUT_W-1)));
    localparam logic [BIN_OUT_W-1:0]  OUT_MAX = {1'b0, {(BIN_OUT_W-1){1'b1}}};
    localparam logic [BIN_OUT_W-1:0]  OUT_MIN = {1'b1, {(BIN_OUT_W-1){1'b0}}};

    logic [ACC_W-1:0] w_cum [CHUNK_BINS];
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_run;

    // Saturating at every step gives the same result as saturating the full sum.
    always_comb begin
        w_run = i_acc;
        w_sum = '0;
        for (int j = CHUNK_BINS - 1; j >= 0; j--) begin
            w_sum    = {1'b0, w_run} + (ACC_W+1)'(i_bins[j*COUNT_W +: COUNT_W]);
            w_run    = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
            w_cum[j] = w_run;
        end
    end

    assign o_next_acc = w_cum[0];

    for (genvar gi = 0; gi < CHUNK_BINS; gi++) begin : g_clamp
        logic signed [ACC_W:0] w_diff;
        assign w_diff = $signed({1'b0, w_cum[gi]}) - $signed({1'b0, i_target});
        assign o_chunk[gi*BIN_OUT_W +: BIN_OUT_W] =
            (w_diff > POS_MAX) ? OUT_MAX :
            (w_diff < NEG_MIN) ? OUT_MIN : w_diff[BIN_OUT_W-1:0];
    end

endmodule

// File: rtl/histogram_chunker.sv
// Per-frame 256-bin intensity histogram, streamed out top-down as 8-bin chunks of
// (pixels at or above bin) - target, for the threshold stage.
module histogram_chunker
    import startracker_pkg::*;
#(
    parameter int TOP     = 1,
    parameter int COUNT_W = 16,
    parameter int ACC_W   = 24
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_frame_start,
    input  logic                            i_frame_end,
    input  logic                            i_pix_valid,
    input  logic [7:0]                      i_pix_data,
    output logic                            o_pix_ready,
    input  logic [ACC_W-1:0]                i_target_count,
    output logic [CHUNK_BINS*BIN_OUT_W-1:0] o_histogram_chunk,
    output logic [7:0]                      o_bin_index,
    output logic                            o_chunk_valid,
    input  logic                            i_chunk_ready,
    output logic                            o_chunk_last,
    output logic                            o_overrun
);

    localparam logic [7:0]         FIRST_BASE = 8'((NUM_CHUNKS - 1) * CHUNK_BINS);
    localparam logic [COUNT_W-1:0] BIN_MAX    = '1;

    // Simulation-only hooks for the top-level instance live in the bench.
    if (TOP != 0) begin : g_top_level
    end

    hc_state_t r_state, w_state_next;

    logic [COUNT_W-1:0]              r_bins [NUM_BINS];
    logic [ACC_W-1:0]                r_target, r_acc;
    logic [7:0]                      r_base;
    logic                            r_all_loaded;
    logic [CHUNK_BINS*BIN_OUT_W-1:0] r_chunk;
    logic [7:0]                      r_bin_index;
    logic                            r_chunk_valid, r_chunk_last, r_overrun;

    logic [CHUNK_BINS*COUNT_W-1:0]   w_chunk_bins;
    logic [CHUNK_BINS*BIN_OUT_W-1:0] w_chunk;
    logic [ACC_W-1:0]                w_next_acc;
    logic w_clear, w_count, w_close, w_load, w_accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_frame_start) w_state_next = ACCUM;
            ACCUM:   if (!i_frame_start && i_frame_end) w_state_next = EMIT;
            EMIT:    if (w_accept && r_chunk_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign o_pix_ready = (r_state != EMIT);
    assign w_clear     = i_frame_start && (r_state != EMIT);
    assign w_count     = (r_state == ACCUM) && i_pix_valid && !i_frame_start;
    assign w_close     = (r_state == ACCUM) && i_frame_end && !i_frame_start;
    assign w_accept    = r_chunk_valid && i_chunk_ready;
    // r_base/r_acc always describe the next chunk to load, so a new chunk can be
    // registered on the same edge the previous one is accepted.
    assign w_load      = (r_state == EMIT) && !r_all_loaded && (!r_chunk_valid || i_chunk_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
        end else if (w_count && (r_bins[i_pix_data] != BIN_MAX)) begin
            r_bins[i_pix_data] <= r_bins[i_pix_data] + 1'b1;
        end
    end

    for (genvar gi = 0; gi < CHUNK_BINS; gi++) begin : g_gather
        assign w_chunk_bins[gi*COUNT_W +: COUNT_W] = r_bins[{r_base[7:3], 3'(gi)}];
    end

    chunk_prefix_sum #(
        .COUNT_W (COUNT_W),
        .ACC_W   (ACC_W)
    ) u_prefix (
        .i_bins     (w_chunk_bins),
        .i_acc      (r_acc),
        .i_target   (r_target),
        .o_chunk    (w_chunk),
        .o_next_acc (w_next_acc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target      <= '0;
            r_acc         <= '0;
            r_base        <= '0;
            r_all_loaded  <= 1'b0;
            r_chunk       <= '0;
            r_bin_index   <= '0;
            r_chunk_valid <= 1'b0;
            r_chunk_last  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (i_frame_start && (r_state == EMIT)) r_overrun <= 1'b1;
            if (w_close) begin
                r_target     <= i_target_count;
                r_acc        <= '0;
                r_base       <= FIRST_BASE;
                r_all_loaded <= 1'b0;
            end
            if (w_load) begin
                r_chunk       <= w_chunk;
                r_bin_index   <= r_base;
                r_chunk_valid <= 1'b1;
                r_chunk_last  <= (r_base == 8'd0);
                r_acc         <= w_next_acc;
                r_base        <= r_base - 8'(CHUNK_BINS);
                if (r_base == 8'd0) r_all_loaded <= 1'b1;
            end else if (w_accept) begin
                r_chunk_valid <= 1'b0;
                r_chunk_last  <= 1'b0;
            end
        end
    end

    assign o_histogram_chunk = r_chunk;
    assign o_bin_index       = r_bin_index;
    assign o_chunk_valid     = r_chunk_valid;
    assign o_chunk_last      = r_chunk_last;
    assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_histogram_chunker.sv
// Directed bench for histogram_chunker: frames with hand-computed chunk values.
module tb_histogram_chunker;

    logic         clk;
    logic         i_rst_n;
    logic         i_frame_start, i_frame_end, i_pix_valid;
    logic [7:0]   i_pix_data;
    logic         o_pix_ready;
    logic [23:0]  i_target_count;
    logic [127:0] o_histogram_chunk;
    logic [7:0]   o_bin_index;
    logic         o_chunk_valid, i_chunk_ready, o_chunk_last, o_overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] got_data [32];
    logic [7:0]   got_idx  [32];
    logic         got_last [32];
    int           got_cyc  [32];
    int           n_got;
    int           n_last;

    histogram_chunker #(.TOP(1), .COUNT_W(16), .ACC_W(24)) dut (
        .i_clk             (clk),
        .i_rst_n           (i_rst_n),
        .i_frame_start     (i_frame_start),
        .i_frame_end       (i_frame_end),
        .i_pix_valid       (i_pix_valid),
        .i_pix_data        (i_pix_data),
        .o_pix_ready       (o_pix_ready),
        .i_target_count    (i_target_count),
        .o_histogram_chunk (o_histogram_chunk),
        .o_bin_index       (o_bin_index),
        .o_chunk_valid     (o_chunk_valid),
        .i_chunk_ready     (i_chunk_ready),
        .o_chunk_last      (o_chunk_last),
        .o_overrun         (o_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
    endtask

    task automatic pixels(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            i_pix_valid = 1'b1;
            i_pix_data  = v;
            step();
        end
        i_pix_valid = 1'b0;
    endtask

    task automatic end_frame(input logic [23:0] tgt, input logic pv, input logic [7:0] pd);
        i_frame_end    = 1'b1;
        i_target_count = tgt;
        i_pix_valid    = pv;
        i_pix_data     = pd;
        step();
        i_frame_end = 1'b0;
        i_pix_valid = 1'b0;
    endtask

    // Drains a frame with ready held high, recording every accepted chunk.
    task automatic collect(input int max_cycles);
        n_got  = 0;
        n_last = 0;
        i_chunk_ready = 1'b1;
        for (int c = 0; c < max_cycles && n_got < 32; c++) begin
            if (o_chunk_valid) begin
                got_data[n_got] = o_histogram_chunk;
                got_idx[n_got]  = o_bin_index;
                got_last[n_got] = o_chunk_last;
                got_cyc[n_got]  = c;
                if (o_chunk_last) n_last++;
                n_got++;
            end
            step();
        end
    endtask

    function automatic logic [127:0] fill(input logic [15:0] v);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[16*j +: 16] = v;
        return r;
    endfunction

    task automatic test_reset();
        logic [127:0] exp;
        tests_run++;
        if ({o_pix_ready, o_chunk_valid, o_chunk_last, o_overrun, o_bin_index} !== {4'b1000, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required %b",
                     {o_pix_ready, o_chunk_valid, o_chunk_last, o_overrun, o_bin_index}, {4'b1000, 8'd0});
        end
        tests_run++;
        if (o_histogram_chunk !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_chunk: got %h required 0", o_histogram_chunk);
        end
        i_rst_n = 1'b1;
        step();
        start_frame();
        pixels(8'd5, 50);
        i_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_pix_ready, o_chunk_valid, o_chunk_last, o_overrun} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL midframe_reset: got %b required 1000",
                     {o_pix_ready, o_chunk_valid, o_chunk_last, o_overrun});
        end
        step();
        i_rst_n = 1'b1;
        step();
        start_frame();
        pixels(8'd200, 3);
        end_frame(24'd0, 1'b0, 8'd0);
        collect(100);
        tests_run++;
        if (n_got !== 32) begin
            tests_failed++;
            $display("FAIL post_reset_count: got %0d required 32", n_got);
        end
        exp = 128'd0;
        exp[15:0] = 16'd3;
        tests_run++;
        if (got_data[6] !== exp) begin
            tests_failed++;
            $display("FAIL post_reset_base200: got %h required %h", got_data[6], exp);
        end
        tests_run++;
        if (got_data[31] !== fill(16'd3)) begin
            tests_failed++;
            $display("FAIL post_reset_base0: got %h required %h", got_data[31], fill(16'd3));
        end
        $display("[TB] reset: mid-frame reset and fresh frame done");
    endtask

    task automatic test_frame();
        logic [127:0] exp;
        start_frame();
        pixels(8'd255, 100);
        pixels(8'd10, 900);
        end_frame(24'd100, 1'b0, 8'd0);
        tests_run++;
        if ({o_chunk_valid, o_pix_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL frame_end_latency: valid,ready got %b required 00", {o_chunk_valid, o_pix_ready});
        end
        collect(100);
        tests_run++;
        if (n_got !== 32 || got_cyc[0] !== 1 || got_cyc[31] - got_cyc[0] !== 31) begin
            tests_failed++;
            $display("FAIL frame_timing: got n=%0d first=%0d last=%0d required n=32 first=1 last=32",
                     n_got, got_cyc[0], got_cyc[31]);
        end
        for (int k = 0; k < 32; k++) begin
            tests_run++;
            if (got_idx[k] !== 8'(248 - 8*k)) begin
                tests_failed++;
                $display("FAIL frame_index[%0d]: got %0d required %0d", k, got_idx[k], 248 - 8*k);
            end
        end
        tests_run++;
        if (got_data[0] !== 128'd0) begin
            tests_failed++;
            $display("FAIL frame_base248: got %h required 0", got_data[0]);
        end
        for (int j = 0; j < 8; j++) exp[16*j +: 16] = (8 + j <= 10) ? 16'd900 : 16'd0;
        tests_run++;
        if (got_data[30] !== exp) begin
            tests_failed++;
            $display("FAIL frame_base8: got %h required %h", got_data[30], exp);
        end
        tests_run++;
        if ({o_chunk_valid, o_pix_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL frame_idle: valid,ready got %b required 01", {o_chunk_valid, o_pix_ready});
        end
        $display("[TB] frame: 32 chunks, target 100");
    endtask

    task automatic test_negative();
        logic [127:0] exp;
        start_frame();
        pixels(8'd255, 100);
        pixels(8'd10, 900);
        end_frame(24'd2000, 1'b0, 8'd0);
        collect(100);
        tests_run++;
        if (got_data[31] !== fill(16'hFC18)) begin
            tests_failed++;
            $display("FAIL neg_base0: got %h required %h", got_data[31], fill(16'hFC18));
        end
        for (int j = 0; j < 8; j++) exp[16*j +: 16] = (8 + j <= 10) ? 16'hFC18 : 16'hF894;
        tests_run++;
        if (got_data[30] !== exp) begin
            tests_failed++;
            $display("FAIL neg_base8: got %h required %h", got_data[30], exp);
        end
        tests_run++;
        if (got_data[0] !== fill(16'hF894)) begin
            tests_failed++;
            $display("FAIL neg_base248: got %h required %h", got_data[0], fill(16'hF894));
        end
        tests_run++;
        if (n_last !== 1 || got_last[31] !== 1'b1) begin
            tests_failed++;
            $display("FAIL last_flag: got count=%0d on_base0=%b required count=1 on_base0=1", n_last, got_last[31]);
        end
        $display("[TB] negative: target 2000 over 1000 pixels");
    endtask

    task automatic test_backpressure();
        logic [127:0] held_data, exp;
        logic [7:0]   held_idx;
        logic         stalled;
        int           n;
        int           a;
        start_frame();
        pixels(8'd255, 100);
        pixels(8'd10, 900);
        end_frame(24'd50, 1'b0, 8'd0);
        n = 0;
        stalled = 1'b0;
        held_data = '0;
        held_idx = '0;
        for (int c = 0; c < 200 && n < 32; c++) begin
            i_chunk_ready = c[0];
            if (o_chunk_valid) begin
                if (stalled) begin
                    tests_run++;
                    if (o_histogram_chunk !== held_data || o_bin_index !== held_idx) begin
                        tests_failed++;
                        $display("FAIL bp_hold: got idx %0d data %h required idx %0d data %h",
                                 o_bin_index, o_histogram_chunk, held_idx, held_data);
                    end
                end
                if (i_chunk_ready) begin
                    for (int j = 0; j < 8; j++) begin
                        a = 248 - 8*n + j;
                        exp[16*j +: 16] = (a <= 10) ? 16'd950 : 16'd50;
                    end
                    tests_run++;
                    if (o_bin_index !== 8'(248 - 8*n) || o_histogram_chunk !== exp) begin
                        tests_failed++;
                        $display("FAIL bp_chunk[%0d]: got idx %0d data %h required idx %0d data %h",
                                 n, o_bin_index, o_histogram_chunk, 248 - 8*n, exp);
                    end
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = o_histogram_chunk;
                    held_idx  = o_bin_index;
                end
            end else begin
                stalled = 1'b0;
            end
            step();
        end
        i_chunk_ready = 1'b1;
        tests_run++;
        if (n !== 32 || o_chunk_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_total: got %0d chunks valid=%b required 32 valid=0", n, o_chunk_valid);
        end
        $display("[TB] backpressure: toggling ready");
    endtask

    task automatic test_saturation();
        logic [127:0] exp;
        start_frame();
        pixels(8'd0, 65540);
        end_frame(24'd0, 1'b0, 8'd0);
        collect(100);
        exp = 128'd0;
        exp[15:0] = 16'h7FFF;
        tests_run++;
        if (got_data[31] !== exp) begin
            tests_failed++;
            $display("FAIL sat_base0: got %h required %h", got_data[31], exp);
        end
        tests_run++;
        if (got_data[0] !== 128'd0 || n_got !== 32) begin
            tests_failed++;
            $display("FAIL sat_base248: got %h n=%0d required 0 n=32", got_data[0], n_got);
        end
        $display("[TB] saturation: 65540 pixels at bin 0");
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        start_frame();
        pixels(8'd77, 37);
        end_frame(24'd0, 1'b0, 8'd0);
        collect(100);
        for (int j = 0; j < 8; j++) exp[16*j +: 16] = (72 + j <= 77) ? 16'd37 : 16'd0;
        tests_run++;
        if (got_data[22] !== exp) begin
            tests_failed++;
            $display("FAIL b2b_base72: got %h required %h", got_data[22], exp);
        end
        tests_run++;
        if (got_data[31] !== fill(16'd37)) begin
            tests_failed++;
            $display("FAIL b2b_base0: got %h required %h", got_data[31], fill(16'd37));
        end
        $display("[TB] back_to_back: 37 identical pixels");
    endtask

    task automatic test_edges();
        logic [127:0] exp;
        i_chunk_ready = 1'b0;
        start_frame();
        pixels(8'd100, 5);
        end_frame(24'd0, 1'b1, 8'd100);
        step();
        tests_run++;
        if (o_chunk_valid !== 1'b1 || o_bin_index !== 8'd248) begin
            tests_failed++;
            $display("FAIL edge_first_valid: got valid=%b idx=%0d required valid=1 idx=248",
                     o_chunk_valid, o_bin_index);
        end
        start_frame();
        tests_run++;
        if ({o_overrun, o_pix_ready, o_chunk_valid} !== 3'b101 || o_bin_index !== 8'd248) begin
            tests_failed++;
            $display("FAIL overrun_set: got ovr,rdy,vld=%b idx=%0d required 101 idx=248",
                     {o_overrun, o_pix_ready, o_chunk_valid}, o_bin_index);
        end
        collect(100);
        for (int j = 0; j < 8; j++) exp[16*j +: 16] = (96 + j <= 100) ? 16'd6 : 16'd0;
        tests_run++;
        if (got_data[19] !== exp || n_got !== 32) begin
            tests_failed++;
            $display("FAIL edge_coincident: got %h n=%0d required %h n=32", got_data[19], n_got, exp);
        end
        tests_run++;
        if ({o_overrun, o_pix_ready, o_chunk_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got ovr,rdy,vld=%b required 110",
                     {o_overrun, o_pix_ready, o_chunk_valid});
        end
        $display("[TB] edges: coincident pixel and overrun");
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_frame_start  = 1'b0;
        i_frame_end    = 1'b0;
        i_pix_valid    = 1'b0;
        i_pix_data     = 8'd0;
        i_target_count = 24'd0;
        i_chunk_ready  = 1'b1;
        step();
        step();
        test_reset();
        test_frame();
        test_negative();
        test_backpressure();
        test_saturation();
        test_back_to_back();
        test_edges();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
